// File: rtl/seg_code_sequencer.sv
// seg_code_sequencer
// Drives the serial prefix-code 7-segment decoder one symbol at a time.
//
// Per symbol:
//   - The symbol index is accepted on a valid/ready handshake.
//   - Its prefix code is shifted MSB-first into the decoder.
//   - The decoded pattern is latched into a stable display register.
//   - The display is held for HOLD_CYCLES cycles before the next symbol.
//
// The decoder is kept in reset whenever no code is being shifted, so idle
// cycles never feed it stray bits.
//
// Optional feature, controlled by macro SEG_CODE_SEQ_CHECK_EN:
//   - Defined: the captured pattern is compared against a built-in table of
//     expected patterns. Any difference sets the sticky Err flag.
//   - Undefined: Err is tied low.

module seg_code_sequencer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] Sym,
  input  logic       Sym_valid,
  output logic       Sym_ready,
  output logic       Dec_I,
  output logic       Dec_Resetn,
  input  logic [6:0] Dec_Q,
  output logic [6:0] Disp,
  output logic       Disp_valid,
  output logic       Err
);

  // A zero hold still needs a legal (1-bit) counter width.
  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic            HOLD_EN   = (HOLD_CYCLES > 0);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  localparam logic [2:0] SYM_BLANK = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    HOLD
  } state_t;

  state_t            state;
  logic [3:0]        shift_reg;
  logic [2:0]        bit_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              blank_sym;
  logic              dec_i_q;
  logic              dec_resetn_q;
  logic [6:0]        disp_q;
  logic              disp_valid_q;
  logic              accept;
  logic [3:0]        sym_code;
  logic [2:0]        sym_len;

  // Transfer happens only in IDLE, and never while reset is asserted.
  assign Sym_ready = (state == IDLE) && !Reset;
  assign accept    = Sym_ready && Sym_valid;

  // Reset also gates the decoder reset combinationally, so the decoder
  // returns to its root on the very edge that resets this block.
  assign Dec_Resetn = dec_resetn_q && !Reset;
  assign Dec_I      = dec_i_q;
  assign Disp       = disp_q;
  assign Disp_valid = disp_valid_q;

  // Prefix code for each symbol, left-aligned in 4 bits, with its length.
  always_comb begin
    sym_code = 4'b0000;
    sym_len  = 3'd0;
    case (Sym)
      3'd0: begin sym_code = 4'b0000; sym_len = 3'd2; end
      3'd1: begin sym_code = 4'b0100; sym_len = 3'd2; end
      3'd2: begin sym_code = 4'b1000; sym_len = 3'd3; end
      3'd3: begin sym_code = 4'b1010; sym_len = 3'd3; end
      3'd4: begin sym_code = 4'b1100; sym_len = 3'd3; end
      3'd5: begin sym_code = 4'b1110; sym_len = 3'd4; end
      3'd6: begin sym_code = 4'b1111; sym_len = 3'd4; end
      default: begin sym_code = 4'b0000; sym_len = 3'd0; end
    endcase
  end

  // Main sequencer FSM.
  //
  // Dec_I is registered one bit ahead. The bit the decoder consumes on an
  // edge is the bit presented during the cycle that precedes that edge.
  //
  // A blank symbol passes through CAPTURE without touching the decoder. This
  // makes it behave like a zero-length code: the display updates one cycle
  // after the accept.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      hold_cnt     <= '0;
      blank_sym    <= 1'b0;
      dec_i_q      <= 1'b0;
      dec_resetn_q <= 1'b0;
      disp_q       <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      disp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          dec_i_q      <= 1'b0;
          dec_resetn_q <= 1'b0;
          if (accept) begin
            if (Sym == SYM_BLANK) begin
              blank_sym <= 1'b1;
              state     <= CAPTURE;
            end else begin
              blank_sym    <= 1'b0;
              dec_i_q      <= sym_code[3];
              shift_reg    <= {sym_code[2:0], 1'b0};
              bit_cnt      <= sym_len;
              dec_resetn_q <= 1'b1;
              state        <= SHIFT;
            end
          end
        end

        SHIFT: begin
          bit_cnt <= bit_cnt - 3'd1;
          if (bit_cnt == 3'd1) begin
            dec_i_q <= 1'b0;
            state   <= CAPTURE;
          end else begin
            dec_i_q   <= shift_reg[3];
            shift_reg <= {shift_reg[2:0], 1'b0};
          end
        end

        CAPTURE: begin
          disp_q       <= blank_sym ? 7'd0 : Dec_Q;
          disp_valid_q <= 1'b1;
          dec_i_q      <= 1'b0;
          dec_resetn_q <= 1'b0;
          if (HOLD_EN) begin
            hold_cnt <= HOLD_LOAD;
            state    <= HOLD;
          end else begin
            state <= IDLE;
          end
        end

        HOLD: begin
          dec_resetn_q <= 1'b0;
          if (hold_cnt <= HOLD_W'(1)) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SEG_CODE_SEQ_CHECK_EN
  logic [2:0] cur_sym;
  logic [6:0] exp_pat;
  logic       err_q;

  // Expected decoder pattern for the symbol currently in flight.
  always_comb begin
    exp_pat = 7'b0000000;
    case (cur_sym)
      3'd0: exp_pat = 7'b1110111;
      3'd1: exp_pat = 7'b1111100;
      3'd2: exp_pat = 7'b0111001;
      3'd3: exp_pat = 7'b1011110;
      3'd4: exp_pat = 7'b1111001;
      3'd5: exp_pat = 7'b1110001;
      3'd6: exp_pat = 7'b0001000;
      default: exp_pat = 7'b0000000;
    endcase
  end

  // Remember the accepted symbol, and latch a sticky error on a capture that
  // differs from the table. Blank symbols are not checked.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cur_sym <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cur_sym <= Sym;
      end
      if (state == CAPTURE && !blank_sym && Dec_Q != exp_pat) begin
        err_q <= 1'b1;
      end
    end
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule
